// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // Header and instruction words are both 4 little-endian bytes, so one packer serves both.
  localparam int HDR_BYTES = 4;

  // Word k lands at byte address 4*(k+1); address 0 is reserved.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return (idx + 32'd1) << 2;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        restart;
  logic        memwrite;
  logic [31:0] pro_addr;
  logic [31:0] pro_data;
  logic        load_done;
  logic        load_error;
  logic [31:0] words_loaded;

  modport slave (
    input  rx_valid, rx_data, restart,
    output memwrite, pro_addr, pro_data, load_done, load_error, words_loaded
  );

  modport master (
    output rx_valid, rx_data, restart,
    input  memwrite, pro_addr, pro_data, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word/word_ready are valid combinationally on the 4th byte.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [31:0] sh_q;

  // Shift right so the first byte ends up in bits 7:0 after four bytes.
  assign word       = {din, sh_q[31:8]};
  assign word_ready = en && (cnt_q == 2'(HDR_BYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed byte stream and writes it word by word into instruction memory.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_WORDS = 23001
) (
  input  logic             clk,
  input  logic             rstn,
  program_loader_if.slave  bus
);

  loader_state_t state_q, state_d;
  logic [31:0]   len_q;
  logic [31:0]   words_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          memwrite_q;

  logic          word_ready;
  logic [31:0]   word;
  logic          last_wr;
  logic          accept;
  logic          rearm;

  // Final write is in flight; bytes arriving now belong to no word.
  assign last_wr = memwrite_q && (words_q == len_q);
  assign accept  = bus.rx_valid &&
                   ((state_q == ST_HDR) || ((state_q == ST_DATA) && !last_wr));
  assign rearm   = bus.restart && ((state_q == ST_DONE) || (state_q == ST_ERROR));

  byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (rearm),
    .en         (accept),
    .din        (bus.rx_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (word_ready) begin
          if (word == 32'd0)                 state_d = ST_DONE;
          else if (word > 32'(MAX_WORDS))    state_d = ST_ERROR;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA:  if (last_wr)     state_d = ST_DONE;
      ST_DONE:  if (bus.restart) state_d = ST_HDR;
      ST_ERROR: if (bus.restart) state_d = ST_HDR;
      default:                   state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      memwrite_q <= 1'b0;
    end else begin
      memwrite_q <= 1'b0;
      if (rearm) begin
        len_q   <= '0;
        words_q <= '0;
      end
      if ((state_q == ST_HDR) && word_ready) len_q <= word;
      if ((state_q == ST_DATA) && word_ready) begin
        memwrite_q <= 1'b1;
        addr_q     <= word_addr(words_q);
        data_q     <= word;
        words_q    <= words_q + 32'd1;
      end
    end
  end

  assign bus.memwrite     = memwrite_q;
  assign bus.pro_addr     = addr_q;
  assign bus.pro_data     = data_q;
  assign bus.load_done    = (state_q == ST_DONE);
  assign bus.load_error   = (state_q == ST_ERROR);
  assign bus.words_loaded = words_q;

endmodule
